// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one shared ALU, one unified memory port (req/ready),
// FETCH/DECODE/EXEC/MEM/WB sequencing, retired-instruction counter and
// a halt on any opcode/funct outside the supported subset.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   mem_req/we/addr/wdata  memory request, held until mem_req & mem_ready
//   mem_rdata, mem_ready   read data and completion from memory
//   PCOut, ALUResultOut    current PC and registered ALU result
//   halted, instret        halt flag and retired-instruction count
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      PCOut,
  output logic [31:0]      ALUResultOut,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_e;

  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sx, imm_zx, pc_plus4, jump_tgt;
  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign imm_sx   = {{16{imm[15]}}, imm};
  assign imm_zx   = {16'h0000, imm};
  assign pc_plus4 = pc_q + 32'd4;
  assign jump_tgt = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  logic is_alu_r, is_jr, is_j, is_jal, is_beq, is_bne, is_addi, is_andi, is_ori;
  logic is_lui, is_lw, is_sw, legal, taken, mem_acc;

  // Instruction class decode from IR
  always_comb begin
    is_alu_r = (opcode == OP_R) &&
               (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL});
    is_jr    = (opcode == OP_R) && (funct == F_JR);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
    is_beq   = (opcode == OP_BEQ);
    is_bne   = (opcode == OP_BNE);
    is_addi  = (opcode == OP_ADDI);
    is_andi  = (opcode == OP_ANDI);
    is_ori   = (opcode == OP_ORI);
    is_lui   = (opcode == OP_LUI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    legal    = is_alu_r | is_jr | is_j | is_jal | is_beq | is_bne | is_addi |
               is_andi | is_ori | is_lui | is_lw | is_sw;
    taken    = is_beq ? (a_q == b_q) : (a_q != b_q);
  end

  // Shared ALU: branch target in DECODE, address/result in EXEC
  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = a_q;
    alu_b  = imm_sx;
    if (state_q == S_DECODE) begin
      alu_a = pc_plus4;
      alu_b = imm_sx << 2;
    end else if (is_alu_r) begin
      alu_b = b_q;
      case (funct)
        F_SUB:   alu_op = ALU_SUB;
        F_AND:   alu_op = ALU_AND;
        F_OR:    alu_op = ALU_OR;
        F_SLT:   alu_op = ALU_SLT;
        F_SLL:   begin alu_op = ALU_SLL; alu_a = b_q; alu_b = 32'(shamt); end
        F_SRL:   begin alu_op = ALU_SRL; alu_a = b_q; alu_b = 32'(shamt); end
        default: alu_op = ALU_ADD;
      endcase
    end else if (is_andi) begin
      alu_op = ALU_AND;
      alu_b  = imm_zx;
    end else if (is_ori) begin
      alu_op = ALU_OR;
      alu_b  = imm_zx;
    end
  end

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_SLT: alu_res = 32'($signed(alu_a) < $signed(alu_b));
      ALU_SLL: alu_res = alu_a << alu_b[4:0];
      ALU_SRL: alu_res = alu_a >> alu_b[4:0];
      default: alu_res = alu_a + alu_b;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_acc) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_beq || is_bne || is_j || is_jr) state_d = S_FETCH;
        else if (is_lw || is_sw)               state_d = S_MEM;
        else                                   state_d = S_WB;
      end
      S_MEM:    if (mem_acc) state_d = is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // FSM outputs; the request is gated by reset so it drops the instant reset asserts
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: if (reset) begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_MEM: if (reset) begin
        mem_req   = 1'b1;
        mem_addr  = alu_out_q;
        mem_we    = is_sw;
        mem_wdata = is_sw ? b_q : 32'h0;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_acc = mem_req & mem_ready;

  // Datapath register updates and retirement
  always_comb begin
    logic retire;
    retire    = 1'b0;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = 32'h0;
    case (state_q)
      S_FETCH: if (mem_acc) ir_d = mem_rdata;
      S_DECODE: begin
        a_d       = rf_q[rs];
        b_d       = rf_q[rt];
        alu_out_d = alu_res;
      end
      S_EXEC: begin
        if (is_beq || is_bne) begin
          pc_d   = taken ? alu_out_q : pc_plus4;
          retire = 1'b1;
        end else if (is_j) begin
          pc_d   = jump_tgt;
          retire = 1'b1;
        end else if (is_jr) begin
          pc_d   = a_q;
          retire = 1'b1;
        end else if (!is_lui && !is_jal) begin
          alu_out_d = alu_res;
        end
      end
      S_MEM: if (mem_acc) begin
        if (is_sw) begin
          pc_d   = pc_plus4;
          retire = 1'b1;
        end else begin
          mdr_d = mem_rdata;
        end
      end
      S_WB: begin
        rf_waddr = is_jal ? 5'd31 : ((opcode == OP_R) ? rd : rt);
        rf_we    = (rf_waddr != 5'd0);
        if (is_jal)      rf_wdata = pc_plus4;
        else if (is_lui) rf_wdata = {imm, 16'h0000};
        else if (is_lw)  rf_wdata = mdr_q;
        else             rf_wdata = alu_out_q;
        pc_d   = is_jal ? jump_tgt : pc_plus4;
        retire = 1'b1;
      end
      default: ;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_out_q <= 32'h0;
      mdr_q     <= 32'h0;
      instret_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign PCOut        = pc_q;
  assign ALUResultOut = alu_out_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: unified memory model with configurable wait
// states, and an instruction-level reference interpreter that predicts every
// memory access plus final PC and retired count.
module tb_mips_multicycle;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clock, reset, mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PCOut, ALUResultOut, instret;

  mips_multicycle #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .PCOut(PCOut), .ALUResultOut(ALUResultOut),
    .halted(halted), .instret(instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        data;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] mem [1024];
  logic [31:0] mm  [1024];
  logic [5:0]  fns [7];
  int          n_assert, n_fail, wmode, wait_left, m_ret;
  logic        busy, m_halt, s_we;
  logic [31:0] s_addr, s_wd, m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hFC00_0000;
      mm[i]  = 32'hFC00_0000;
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
    mm[a[11:2]]  = w;
  endtask

  // Instruction-set interpreter: fills the expected-access queue
  task automatic model_run();
    logic [31:0] r [32];
    logic [31:0] pc, ins, nxt, wd, se, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic        wr, ok;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    pc = RPC; m_ret = 0; m_halt = 1'b0; exp_q.delete();
    for (int n = 0; n < 4000 && !m_halt; n++) begin
      ins = mm[pc[11:2]];
      exp_q.push_back('{addr: pc, we: 1'b0, wdata: 32'h0, data: 1'b0});
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      sh = ins[10:6];  fn = ins[5:0];
      se = {{16{ins[15]}}, ins[15:0]};
      nxt = pc + 32'd4; wr = 1'b0; ok = 1'b1; dst = rt; wd = 32'h0;
      case (op)
        6'h00: begin
          dst = rd; wr = 1'b1;
          case (fn)
            6'h20: wd = r[rs] + r[rt];
            6'h22: wd = r[rs] - r[rt];
            6'h24: wd = r[rs] & r[rt];
            6'h25: wd = r[rs] | r[rt];
            6'h2A: wd = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
            6'h00: wd = r[rt] << sh;
            6'h02: wd = r[rt] >> sh;
            6'h08: begin wr = 1'b0; nxt = r[rs]; end
            default: ok = 1'b0;
          endcase
        end
        6'h08: begin wr = 1'b1; wd = r[rs] + se; end
        6'h0C: begin wr = 1'b1; wd = r[rs] & {16'h0, ins[15:0]}; end
        6'h0D: begin wr = 1'b1; wd = r[rs] | {16'h0, ins[15:0]}; end
        6'h0F: begin wr = 1'b1; wd = {ins[15:0], 16'h0}; end
        6'h23: begin
          ea = r[rs] + se;
          exp_q.push_back('{addr: ea, we: 1'b0, wdata: 32'h0, data: 1'b1});
          wr = 1'b1; wd = mm[ea[11:2]];
        end
        6'h2B: begin
          ea = r[rs] + se;
          exp_q.push_back('{addr: ea, we: 1'b1, wdata: r[rt], data: 1'b1});
          mm[ea[11:2]] = r[rt];
        end
        6'h04: if (r[rs] == r[rt]) nxt = pc + 32'd4 + (se << 2);
        6'h05: if (r[rs] != r[rt]) nxt = pc + 32'd4 + (se << 2);
        6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
        6'h03: begin wr = 1'b1; dst = 5'd31; wd = pc + 32'd4; nxt = {nxt[31:28], ins[25:0], 2'b00}; end
        default: ok = 1'b0;
      endcase
      if (!ok) m_halt = 1'b1;
      else begin
        if (wr && dst != 5'd0) r[dst] = wd;
        pc = nxt;
        m_ret++;
      end
    end
    m_pc = pc;
  endtask

  // One clock: drive memory at negedge, sample #1 after posedge
  task automatic step();
    acc_t        e;
    logic        acc, awe, front_data;
    logic [31:0] aa, aw;
    @(negedge clock);
    if (mem_req) begin
      if (!busy) begin
        busy = 1'b1; s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
        front_data = (exp_q.size() != 0) && exp_q[0].data;
        case (wmode)
          1:       wait_left = $urandom_range(0, 2);
          3:       wait_left = front_data ? 2 : 0;
          4:       wait_left = front_data ? 1000 : 0;
          default: wait_left = 0;
        endcase
      end else begin
        chk("stable_addr", mem_addr, s_addr);
        chk("stable_we", 32'(mem_we), 32'(s_we));
        chk("stable_wdata", mem_wdata, s_wd);
      end
      mem_ready = (wait_left == 0);
      if (wait_left != 0) wait_left--;
    end else begin
      busy = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
    end
    mem_rdata = mem[mem_addr[11:2]];
    acc = mem_req && mem_ready; aa = mem_addr; awe = mem_we; aw = mem_wdata;
    @(posedge clock); #1;
    if (acc) begin
      busy = 1'b0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '{addr: 32'hDEAD_BEEF, we: 1'b1, wdata: 32'h0, data: 1'b0};
      chk("acc_addr", aa, e.addr);
      chk("acc_we", 32'(awe), 32'(e.we));
      if (e.we) chk("acc_wdata", aw, e.wdata);
      if (awe) mem[aa[11:2]] = aw;
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b0; busy = 1'b0; wait_left = 0; mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_pc", PCOut, RPC);
    chk("rst_instret", instret, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_aluout", ALUResultOut, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1; #1;
    chk("c1_req", 32'(mem_req), 32'd1);
    chk("c1_addr", mem_addr, RPC);
    chk("c1_we", 32'(mem_we), 32'd0);
  endtask

  task automatic run_to_halt(input int budget);
    int c;
    c = 0;
    while (!halted && c < budget) begin step(); c++; end
    chk("end_halted", 32'(halted), 32'd1);
    chk("end_pc", PCOut, m_pc);
    chk("end_instret", instret, 32'(m_ret));
    chk("end_queue_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] pa, w;
    logic [4:0]  rs, rt, rd;
    logic [15:0] im, off;
    int          kind, c;
    n_assert = 0; n_fail = 0; wmode = 0; busy = 1'b0; wait_left = 0;
    reset = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};

    // Directed program A: ALU, waited store/load, branches, lui
    clear_mem();
    load(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    load(32'h104, enc_r(6'h20, 5'd1, 5'd1, 5'd2, 5'd0));
    load(32'h108, enc_i(6'h2B, 5'd0, 5'd2, 16'd8));
    load(32'h10C, enc_i(6'h23, 5'd0, 5'd3, 16'd8));
    load(32'h110, enc_i(6'h2B, 5'd0, 5'd3, 16'd12));
    load(32'h114, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    load(32'h120, enc_i(6'h05, 5'd1, 5'd1, 16'd2));
    load(32'h124, enc_i(6'h0F, 5'd0, 5'd4, 16'hABCD));
    load(32'h128, enc_i(6'h2B, 5'd0, 5'd4, 16'd16));
    model_run();
    wmode = 0;
    do_reset();
    steps(8);
    chk("a_instret_alu", instret, 32'd2);
    chk("a_aluout_add", ALUResultOut, 32'd10);
    wmode = 3;
    steps(6);
    chk("a_instret_sw_wait", instret, 32'd3);
    steps(7);
    chk("a_instret_lw_wait", instret, 32'd4);
    wmode = 0;
    steps(4);
    chk("a_instret_sw", instret, 32'd5);
    steps(3);
    chk("a_beq_pc", PCOut, 32'h120);
    steps(3);
    chk("a_bne_pc", PCOut, 32'h124);
    steps(8);
    chk("a_instret_lui_sw", instret, 32'd9);
    steps(2);
    chk("a_halted", 32'(halted), 32'd1);
    chk("a_halt_pc", PCOut, 32'h12C);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("a_halt_req", 32'(mem_req), 32'd0);
      chk("a_halt_instret", instret, 32'd9);
    end
    run_to_halt(10);
    chk("a_mem_lw_copy", mem[3], 32'd10);
    chk("a_mem_lui", mem[4], 32'hABCD_0000);

    // Directed program B: j, jal, taken bne, jr
    clear_mem();
    load(32'h100, enc_i(6'h05, 5'd31, 5'd0, 16'd1));
    load(32'h104, enc_j(6'h02, 26'h8));
    load(32'h108, enc_i(6'h2B, 5'd0, 5'd31, 16'd20));
    load(32'h10C, enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0));
    load(32'h020, enc_j(6'h03, 26'h40));
    model_run();
    wmode = 0;
    do_reset();
    steps(10);
    chk("b_jal_pc", PCOut, 32'h100);
    chk("b_jal_instret", instret, 32'd3);
    steps(3);
    chk("b_bne_taken_pc", PCOut, 32'h108);
    steps(7);
    chk("b_jr_pc", PCOut, 32'h24);
    chk("b_jr_instret", instret, 32'd6);
    steps(2);
    chk("b_halted", 32'(halted), 32'd1);
    run_to_halt(10);
    chk("b_ra_stored", mem[5], 32'h24);

    // Random programs with random wait states
    for (int t = 0; t < 3; t++) begin
      clear_mem();
      for (int i = 0; i < 16; i++) load(32'h300 + 32'(4 * i), $urandom);
      pa = RPC;
      for (int k = 0; k < 40; k++) begin
        kind = $urandom_range(0, 13);
        rs   = 5'($urandom_range(0, 7));
        rt   = 5'($urandom_range(1, 7));
        rd   = 5'($urandom_range(0, 7));
        im   = 16'($urandom);
        off  = 16'(32'h300 + 32'(4 * $urandom_range(0, 15)));
        case (kind)
          0, 1, 2, 3, 4, 5, 6: w = enc_r(fns[kind], rs, rt, rd, 5'($urandom));
          7:  w = enc_i(6'h08, rs, rt, im);
          8:  w = enc_i(6'h0C, rs, rt, im);
          9:  w = enc_i(6'h0D, rs, rt, im);
          10: w = enc_i(6'h0F, 5'd0, rt, im);
          11: w = enc_i(6'h23, 5'd0, rt, off);
          12: w = enc_i(6'h2B, 5'd0, rt, off);
          default: w = enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, 16'd1);
        endcase
        load(pa, w);
        pa = pa + 32'd4;
      end
      for (int i = 1; i < 8; i++) begin
        load(pa, enc_i(6'h2B, 5'd0, 5'(i), 16'(32'h380 + 32'(4 * i))));
        pa = pa + 32'd4;
      end
      model_run();
      wmode = 1;
      do_reset();
      run_to_halt(3000);
    end

    // Reset asserted while a load waits in MEM
    clear_mem();
    load(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd9));
    load(32'h104, enc_i(6'h23, 5'd0, 5'd1, 16'h300));
    load(32'h108, enc_i(6'h2B, 5'd0, 5'd1, 16'h304));
    load(32'h300, 32'h55);
    load(32'h304, 32'h77);
    model_run();
    wmode = 4;
    do_reset();
    c = 0;
    while (!(mem_req && mem_addr == 32'h300) && c < 20) begin step(); c++; end
    chk("d_reached_mem", 32'(mem_req), 32'd1);
    step();
    chk("d_still_waiting", 32'(mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("d_req_drop", 32'(mem_req), 32'd0);
    chk("d_pc_restart", PCOut, RPC);
    chk("d_instret_clr", instret, 32'd0);
    chk("d_no_store", mem[32'h304 >> 2], 32'h77);
    model_run();
    wmode = 0;
    do_reset();
    run_to_halt(50);
    chk("d_store_after_rerun", mem[32'h304 >> 2], 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
